// File: rtl/alu_pkg.sv
// Shared ALU definitions: alu1 control encoding and the serial ALU state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_OR  = 3'd5;
  localparam logic [2:0] ALU_NOR = 3'd6;
  localparam logic [2:0] ALU_XOR = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu1.sv
// One-bit ALU slice: full adder with B inversion for SUB, plus bitwise logic ops.
module alu1
  import alu_pkg::*;
(
  output logic       out,
  output logic       cout,
  input  logic       A,
  input  logic       B,
  input  logic       carryin,
  input  logic [2:0] control
);

  logic b_eff;
  logic sum;

  always_comb begin
    b_eff = (control == ALU_SUB) ? ~B : B;
    sum   = A ^ b_eff ^ carryin;
    cout  = (A & b_eff) | (A & carryin) | (b_eff & carryin);
    case (control)
      ALU_AND: out = A & B;
      ALU_OR:  out = A | B;
      ALU_NOR: out = ~(A | B);
      ALU_XOR: out = A ^ B;
      default: out = sum;
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial WIDTH-bit ALU: one alu1 slice per clock, LSB first, with a
// start/busy/done handshake and result/flags held until the next completion.
module alu_serial
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       alu_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] res_sr_q;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] out_q;
  logic             overflow_q;
  logic             zero_q;
  logic             negative_q;

  logic             slice_out;
  logic             slice_cout;
  logic [WIDTH-1:0] res_d;
  logic             last_bit;
  logic             is_arith;

  alu1 u_alu1 (
    .out     (slice_out),
    .cout    (slice_cout),
    .A       (a_sr_q[0]),
    .B       (b_sr_q[0]),
    .carryin (carry_q),
    .control (op_q)
  );

  assign res_d    = {slice_out, res_sr_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  assign is_arith = (op_q == ALU_ADD) || (op_q == ALU_SUB);

  // Control FSM and serial datapath; flags and out update only on entry to DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      a_sr_q     <= '0;
      b_sr_q     <= '0;
      res_sr_q   <= '0;
      op_q       <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      out_q      <= '0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_sr_q  <= A;
            b_sr_q  <= B;
            op_q    <= alu_op;
            cnt_q   <= '0;
            carry_q <= alu_op[0];
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_sr_q   <= {1'b0, a_sr_q[WIDTH-1:1]};
          b_sr_q   <= {1'b0, b_sr_q[WIDTH-1:1]};
          res_sr_q <= res_d;
          carry_q  <= slice_cout;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            // On the MSB step carry_q is the carry into the MSB.
            out_q      <= res_d;
            overflow_q <= is_arith & (carry_q ^ slice_cout);
            zero_q     <= (res_d == '0);
            negative_q <= slice_out;
            state_q    <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign out      = out_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;
  assign negative = negative_q;

endmodule

// File: tb/tb_alu_serial.sv
// Self-checking bench for alu_serial (WIDTH=32 and WIDTH=4 instances) with a result scoreboard.
module tb_alu_serial;

  typedef struct packed {
    logic [31:0] res;
    logic        ov;
    logic        z;
    logic        n;
  } exp_t;

  typedef struct packed {
    logic [3:0] res;
    logic       ov;
    logic       z;
    logic       n;
  } exp4_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic [2:0]  op;
  logic        busy, done, ov, zero, neg;
  logic [31:0] dout;

  logic        start4;
  logic [3:0]  a4, b4;
  logic [2:0]  op4;
  logic        busy4, done4, ov4, zero4, neg4;
  logic [3:0]  dout4;

  exp_t  exp_q[$];
  exp4_t exp4_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  alu_serial #(.WIDTH(32)) u_dut (
    .clock(clk), .reset(reset), .start(start), .A(a), .B(b), .alu_op(op),
    .busy(busy), .done(done), .out(dout), .overflow(ov), .zero(zero), .negative(neg)
  );

  alu_serial #(.WIDTH(4)) u_dut4 (
    .clock(clk), .reset(reset), .start(start4), .A(a4), .B(b4), .alu_op(op4),
    .busy(busy4), .done(done4), .out(dout4), .overflow(ov4), .zero(zero4), .negative(neg4)
  );

  function automatic exp_t model32(input logic [31:0] x, input logic [31:0] y, input logic [2:0] o);
    exp_t e;
    e.res = 32'h0;
    e.ov  = 1'b0;
    case (o)
      3'd2: begin e.res = x + y; e.ov = (x[31] == y[31]) && (e.res[31] != x[31]); end
      3'd3: begin e.res = x - y; e.ov = (x[31] != y[31]) && (e.res[31] != x[31]); end
      3'd4: e.res = x & y;
      3'd5: e.res = x | y;
      3'd6: e.res = ~(x | y);
      3'd7: e.res = x ^ y;
      default: e.res = 32'h0;
    endcase
    e.z = (e.res == 32'h0);
    e.n = e.res[31];
    return e;
  endfunction

  function automatic exp4_t model4(input logic [3:0] x, input logic [3:0] y, input logic [2:0] o);
    exp4_t e;
    if (o == 3'd3) begin
      e.res = x - y;
      e.ov  = (x[3] != y[3]) && (e.res[3] != x[3]);
    end else begin
      e.res = x + y;
      e.ov  = (x[3] == y[3]) && (e.res[3] != x[3]);
    end
    e.z = (e.res == 4'h0);
    e.n = e.res[3];
    return e;
  endfunction

  // Drive one 32-bit op, optionally pulse start mid-RUN, and wait for done (lat=-1 on timeout).
  task automatic do_op(input logic [31:0] a_v, input logic [31:0] b_v, input logic [2:0] op_v,
                       input int inject_at, output int lat);
    exp_q.push_back(model32(a_v, b_v, op_v));
    @(negedge clk);
    start = 1'b1; a = a_v; b = b_v; op = op_v;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (k == inject_at) begin
        start = 1'b1; a = $urandom; b = $urandom; op = 3'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; a = 32'h1234_5678; b = 32'h1; op = 3'd2;
    start4 = 1'b1; a4 = 4'h3; b4 = 4'h1; op4 = 3'd2;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, dout, ov, zero, neg} !== 37'h0) begin
      n_err++;
      $display("FAIL reset32: busy=%b done=%b out=%h ov=%b z=%b n=%b, want all 0", busy, done, dout, ov, zero, neg);
    end
    n_vec++;
    if ({busy4, done4, dout4, ov4, zero4, neg4} !== 9'h0) begin
      n_err++;
      $display("FAIL reset4: busy=%b done=%b out=%h ov=%b z=%b n=%b, want all 0", busy4, done4, dout4, ov4, zero4, neg4);
    end
    reset = 1'b0; start = 1'b0; start4 = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_idle: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_add_overflow;
    int   lat;
    exp_t e;
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 3'd2, 0, lat);
    e = exp_q.pop_front();
    n_vec++;
    if (lat !== 33) begin
      n_err++;
      $display("FAIL add_latency: got %0d negedges, want 33", lat);
    end
    n_vec++;
    if ({dout, ov, zero, neg} !== e) begin
      n_err++;
      $display("FAIL add_ovf: out=%h ov=%b z=%b n=%b, want out=%h ov=%b z=%b n=%b", dout, ov, zero, neg, e.res, e.ov, e.z, e.n);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || dout !== e.res) begin
      n_err++;
      $display("FAIL done_pulse_hold: done=%b out=%h, want done=0 out=%h", done, dout, e.res);
    end
  endtask

  task automatic test_sub;
    logic [31:0] va [2] = '{32'h5, 32'h8000_0000};
    logic [31:0] vb [2] = '{32'h5, 32'h1};
    int   lat;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      do_op(va[i], vb[i], 3'd3, 0, lat);
      e = exp_q.pop_front();
      n_vec++;
      if (lat !== 33 || {dout, ov, zero, neg} !== e) begin
        n_err++;
        $display("FAIL sub_%0d: lat=%0d out=%h ov=%b z=%b n=%b, want lat=33 out=%h ov=%b z=%b n=%b",
                 i, lat, dout, ov, zero, neg, e.res, e.ov, e.z, e.n);
      end
    end
  endtask

  task automatic test_logic;
    int   lat;
    exp_t e;
    for (int o = 4; o <= 7; o++) begin
      do_op(32'hF0F0_F0F0, 32'hFF00_FF00, 3'(o), 0, lat);
      e = exp_q.pop_front();
      n_vec++;
      if (lat !== 33 || {dout, ov, zero, neg} !== e) begin
        n_err++;
        $display("FAIL logic_op%0d: lat=%0d out=%h ov=%b z=%b n=%b, want lat=33 out=%h ov=%b z=%b n=%b",
                 o, lat, dout, ov, zero, neg, e.res, e.ov, e.z, e.n);
      end
    end
    for (int i = 0; i < 4; i++) begin
      do_op($urandom, $urandom, 3'(2 + (i % 2)), 0, lat);
      e = exp_q.pop_front();
      n_vec++;
      if (lat !== 33 || {dout, ov, zero, neg} !== e) begin
        n_err++;
        $display("FAIL rand_arith_%0d: lat=%0d out=%h ov=%b z=%b n=%b, want out=%h ov=%b z=%b n=%b",
                 i, lat, dout, ov, zero, neg, e.res, e.ov, e.z, e.n);
      end
    end
  endtask

  task automatic test_ignore_start;
    int   lat;
    exp_t e;
    do_op(32'd10, 32'd20, 3'd2, 5, lat);
    e = exp_q.pop_front();
    n_vec++;
    if (lat !== 33 || {dout, ov, zero, neg} !== e) begin
      n_err++;
      $display("FAIL start_mid_run: lat=%0d out=%h ov=%b, want lat=33 out=%h ov=%b", lat, dout, ov, e.res, e.ov);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL start_not_queued: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] va [3] = '{32'h1111_1111, 32'h8000_0000, 32'hAAAA_5555};
    logic [31:0] vb [3] = '{32'h2222_2222, 32'h8000_0000, 32'h0F0F_0F0F};
    logic [2:0]  vo [3] = '{3'd2, 3'd2, 3'd7};
    int   idx = 0;
    int   since = 0;
    int   ndone = 0;
    exp_t e;
    exp_q.push_back(model32(va[0], vb[0], vo[0]));
    @(negedge clk);
    start = 1'b1; a = va[0]; b = vb[0]; op = vo[0];
    idx = 1;
    for (int k = 0; k < 120 && ndone < 3; k++) begin
      @(negedge clk);
      since++;
      n_vec++;
      if (busy !== !done) begin
        n_err++;
        $display("FAIL b2b_busy: cycle %0d busy=%b done=%b, want busy=!done", k, busy, done);
      end
      if (done === 1'b1) begin
        e = exp_q.pop_front();
        n_vec++;
        if (since !== 33 || {dout, ov, zero, neg} !== e) begin
          n_err++;
          $display("FAIL b2b_result_%0d: interval=%0d out=%h ov=%b z=%b n=%b, want 33 out=%h ov=%b z=%b n=%b",
                   ndone, since, dout, ov, zero, neg, e.res, e.ov, e.z, e.n);
        end
        since = 0;
        ndone++;
        if (idx < 3) begin
          exp_q.push_back(model32(va[idx], vb[idx], vo[idx]));
          a = va[idx]; b = vb[idx]; op = vo[idx];
          idx++;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    n_vec++;
    if (ndone !== 3) begin
      n_err++;
      $display("FAIL b2b_count: got %0d done pulses, want 3", ndone);
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid;
    int   lat;
    logic seen_done = 1'b0;
    exp_t e;
    @(negedge clk);
    start = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0101_0101; op = 3'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({busy, done, dout, ov, zero, neg} !== 37'h0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b done=%b out=%h ov=%b z=%b n=%b, want all 0", busy, done, dout, ov, zero, neg);
    end
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      seen_done |= done;
    end
    n_vec++;
    if (seen_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_no_done: done seen=%b, want 0", seen_done);
    end
    do_op(32'd3, 32'd4, 3'd2, 0, lat);
    e = exp_q.pop_front();
    n_vec++;
    if (lat !== 33 || {dout, ov, zero, neg} !== e) begin
      n_err++;
      $display("FAIL after_reset_add: lat=%0d out=%h, want lat=33 out=%h", lat, dout, e.res);
    end
  endtask

  task automatic test_width4;
    logic [3:0] va [3] = '{4'h7, 4'h8, 4'hF};
    logic [3:0] vb [3] = '{4'h1, 4'h1, 4'h1};
    logic [2:0] vo [3] = '{3'd2, 3'd3, 3'd2};
    int    lat;
    exp4_t e;
    for (int i = 0; i < 3; i++) begin
      exp4_q.push_back(model4(va[i], vb[i], vo[i]));
      @(negedge clk);
      start4 = 1'b1; a4 = va[i]; b4 = vb[i]; op4 = vo[i];
      @(negedge clk);
      start4 = 1'b0;
      lat = -1;
      for (int k = 1; k <= 10; k++) begin
        if (done4) begin
          lat = k;
          break;
        end
        @(negedge clk);
      end
      e = exp4_q.pop_front();
      n_vec++;
      if (lat !== 5 || {dout4, ov4, zero4, neg4} !== e) begin
        n_err++;
        $display("FAIL w4_%0d: lat=%0d out=%h ov=%b z=%b n=%b, want lat=5 out=%h ov=%b z=%b n=%b",
                 i, lat, dout4, ov4, zero4, neg4, e.res, e.ov, e.z, e.n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub();
    test_logic();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_width4();
    n_vec++;
    if (exp_q.size() != 0 || exp4_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, want 0", exp_q.size(), exp4_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
